// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the cache/memory arbiter: FSM states, owner tags and
// the memory read latency also used by the memory model and cache fill counters.
package mem_arbiter_pkg;

  localparam int MEM_LATENCY_DEF = 4;
  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_OWN = 2'd1,
    D_OWN = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } tag_t;

  // On a simultaneous request the side that did not own memory last wins.
  function automatic arb_state_e tie_winner(input owner_e last_owner);
    return (last_owner == OWNER_I) ? D_OWN : I_OWN;
  endfunction

endpackage

// File: rtl/mem_arbiter_tag_pipe.sv
// Read-return tag pipeline: one {valid, owner} entry per cycle of memory
// latency, so the tail lines up with the matching mem_data_valid pulse.
module arb_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = MEM_LATENCY_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_vld,
  input  owner_e push_owner,
  output logic   tail_vld,
  output owner_e tail_owner
);

  tag_t [DEPTH-1:0] tag_q;
  tag_t [DEPTH-1:0] tag_d;

  always_comb begin
    tag_d          = tag_q;
    tag_d[0].vld   = push_vld;
    // Invalid slots carry a fixed owner so the pipe never holds stale routing.
    tag_d[0].owner = push_vld ? push_owner : OWNER_I;
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_q <= '0;
    else     tag_q <= tag_d;
  end

  assign tail_vld   = tag_q[DEPTH-1].vld;
  assign tail_owner = tag_q[DEPTH-1].owner;

endmodule

// File: rtl/mem_arbiter.sv
// Two-cache front end for the single main-memory port: non-preemptive
// ownership FSM with alternating tie-break, and tagged routing of read returns.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_data_valid,
  output logic [DATA_W-1:0] cache_rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output logic              protocol_err
);

  arb_state_e state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  logic       protocol_err_q, protocol_err_d;

  logic       i_req, d_req;
  logic       push_vld;
  owner_e     push_owner;
  logic       tail_vld;
  owner_e     tail_owner;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  always_comb begin
    state_d        = state_q;
    last_owner_d   = last_owner_q;
    protocol_err_d = protocol_err_q;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_data_in    = '0;

    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) state_d = tie_winner(last_owner_q);
        else if (d_req)     state_d = D_OWN;
        else if (i_req)     state_d = I_OWN;
      end

      I_OWN: begin
        if (i_req) begin
          mem_enable  = 1'b1;
          mem_addr    = i_addr;
          mem_data_in = d_wdata;
        end else begin
          state_d      = IDLE;
          last_owner_d = OWNER_I;
        end
      end

      D_OWN: begin
        if (d_req) begin
          mem_enable  = 1'b1;
          mem_addr    = d_addr;
          // Read and write together is illegal; the write takes the port.
          mem_wr      = d_mem_write;
          mem_data_in = d_wdata;
          if (d_mem_read && d_mem_write) protocol_err_d = 1'b1;
        end else begin
          state_d      = IDLE;
          last_owner_d = OWNER_D;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_owner_q   <= OWNER_I;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Only reads are tagged; writes and idle cycles push an empty slot.
  assign push_vld   = mem_enable & ~mem_wr;
  assign push_owner = (state_q == D_OWN) ? OWNER_D : OWNER_I;

  arb_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_vld   (push_vld),
    .push_owner (push_owner),
    .tail_vld   (tail_vld),
    .tail_owner (tail_owner)
  );

  // A return whose tail slot is empty (e.g. issued before reset) is dropped.
  assign i_data_valid = mem_data_valid & tail_vld & (tail_owner == OWNER_I);
  assign d_data_valid = mem_data_valid & tail_vld & (tail_owner == OWNER_D);

  assign i_grant      = (state_q == I_OWN);
  assign d_grant      = (state_q == D_OWN);
  assign protocol_err = protocol_err_q;
  assign cache_rdata  = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory whose read data
// equals the read address.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_read, d_mem_read, d_mem_write;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, d_grant, i_data_valid, d_data_valid;
  logic [15:0] cache_rdata, mem_addr, mem_data_in, mem_data_out;
  logic        mem_enable, mem_wr, mem_data_valid, protocol_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int first_i_cyc = -1;
  int first_issue = 0;
  int en_cnt      = 0;
  int mv_cnt      = 0;
  logic [15:0] iq [$];
  logic [15:0] dq [$];

  // Memory model: data_valid four cycles after a read issue; memory is not reset.
  logic [3:0]  mv = '0;
  logic [15:0] ma [4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    mv    <= {mv[2:0], mem_enable & ~mem_wr};
    ma[0] <= mem_addr;
    ma[1] <= ma[0];
    ma[2] <= ma[1];
    ma[3] <= ma[2];
  end

  assign mem_data_valid = mv[3];
  assign mem_data_out   = mv[3] ? ma[3] : 16'h0000;

  always @(negedge clk) begin
    if (mem_data_valid) mv_cnt++;
    if (i_data_valid) begin
      if (iq.size() == 0) first_i_cyc = cyc;
      iq.push_back(cache_rdata);
    end
    if (d_data_valid) dq.push_back(cache_rdata);
  end

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_mem_read     (i_mem_read),
    .i_addr         (i_addr),
    .i_grant        (i_grant),
    .i_data_valid   (i_data_valid),
    .d_mem_read     (d_mem_read),
    .d_mem_write    (d_mem_write),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_grant        (d_grant),
    .d_data_valid   (d_data_valid),
    .cache_rdata    (cache_rdata),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid),
    .protocol_err   (protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    iq.delete();
    dq.delete();
    first_i_cyc = -1;
  endtask

  function automatic logic [15:0] qget(input logic [15:0] q [$], input int j);
    return (j < q.size()) ? q[j] : 16'hDEAD;
  endfunction

  initial begin
    rst = 1'b1; i_mem_read = 0; d_mem_read = 0; d_mem_write = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (2) tick();
    #1;
    chk("rst_i_grant", i_grant, 0);
    chk("rst_d_grant", d_grant, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_protocol_err", protocol_err, 0);
    chk("rst_data_valid", {i_data_valid, d_data_valid}, 0);
    rst = 1'b0;

    // I-fill after reset: 8 reads, one IDLE cycle before the first issue
    tick(); clr();
    i_mem_read = 1; i_addr = 16'h0000;
    #1;
    chk("ifill_idle_grant", i_grant, 0);
    chk("ifill_idle_enable", mem_enable, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      i_addr = 16'(2 * k);
      if (k == 0) first_issue = cyc;
      #1;
      chk("ifill_grant", i_grant, 1);
      chk("ifill_addr", mem_addr, 32'(2 * k));
      if (mem_enable) en_cnt++;
    end
    tick(); i_mem_read = 0; #1;
    chk("ifill_release_enable", mem_enable, 0);
    chk("ifill_release_grant", i_grant, 1);
    tick(); #1;
    chk("ifill_idle_after", i_grant, 0);
    repeat (6) tick();
    chk("ifill_enable_cycles", en_cnt, 8);
    chk("ifill_count", iq.size(), 8);
    for (int j = 0; j < 8; j++) chk("ifill_word", qget(iq, j), 32'(2 * j));
    chk("ifill_latency", first_i_cyc - first_issue, 4);
    chk("ifill_no_d", dq.size(), 0);

    // First tie after reset goes to D
    rst = 1'b1; tick(); rst = 1'b0; clr();
    i_mem_read = 1; i_addr = 16'h0100; d_mem_read = 1; d_addr = 16'h0200;
    #1;
    chk("tie_idle_grants", {i_grant, d_grant}, 0);
    for (int k = 0; k < 4; k++) begin
      tick(); d_addr = 16'h0200 + 16'(2 * k); #1;
      chk("tie_d_grant", {i_grant, d_grant}, 2'b01);
      chk("tie_d_addr", mem_addr, 32'h0200 + 32'(2 * k));
    end
    tick(); d_mem_read = 0; #1;
    chk("tie_d_release_enable", mem_enable, 0);
    chk("tie_d_release_grants", {i_grant, d_grant}, 2'b01);
    tick(); #1;
    chk("tie_idle_gap", {i_grant, d_grant}, 2'b00);
    for (int k = 0; k < 4; k++) begin
      tick(); i_addr = 16'h0100 + 16'(2 * k); #1;
      chk("tie_i_grant", {i_grant, d_grant}, 2'b10);
      chk("tie_i_addr", mem_addr, 32'h0100 + 32'(2 * k));
    end
    tick(); i_mem_read = 0;
    repeat (7) tick();
    chk("tie_d_count", dq.size(), 4);
    chk("tie_i_count", iq.size(), 4);
    for (int j = 0; j < 4; j++) begin
      chk("tie_d_word", qget(dq, j), 32'h0200 + 32'(2 * j));
      chk("tie_i_word", qget(iq, j), 32'h0100 + 32'(2 * j));
    end

    // Mid-burst contention: D asks at I's third issue
    clr();
    i_mem_read = 1; i_addr = 16'h0300;
    for (int k = 0; k < 8; k++) begin
      tick(); i_addr = 16'h0300 + 16'(2 * k);
      if (k == 2) begin d_mem_read = 1; d_addr = 16'h0400; end
      #1;
      chk("mid_i_grant", {i_grant, d_grant}, 2'b10);
      chk("mid_i_addr", mem_addr, 32'h0300 + 32'(2 * k));
    end
    tick(); i_mem_read = 0; #1;
    chk("mid_release_d_grant", d_grant, 0);
    chk("mid_release_enable", mem_enable, 0);
    tick(); #1;
    chk("mid_idle_gap", {i_grant, d_grant}, 2'b00);
    for (int k = 0; k < 8; k++) begin
      tick(); d_addr = 16'h0400 + 16'(2 * k); #1;
      chk("mid_d_grant", {i_grant, d_grant}, 2'b01);
      chk("mid_d_addr", mem_addr, 32'h0400 + 32'(2 * k));
    end
    tick(); d_mem_read = 0;
    repeat (7) tick();
    chk("mid_i_count", iq.size(), 8);
    chk("mid_d_count", dq.size(), 8);
    for (int j = 0; j < 8; j++) begin
      chk("mid_i_word", qget(iq, j), 32'h0300 + 32'(2 * j));
      chk("mid_d_word", qget(dq, j), 32'h0400 + 32'(2 * j));
    end

    // Write-through store
    clr();
    d_mem_write = 1; d_addr = 16'h0040; d_wdata = 16'h1234; #1;
    chk("wr_idle_grant", d_grant, 0);
    tick(); #1;
    chk("wr_grant", d_grant, 1);
    chk("wr_bus", {mem_enable, mem_wr, mem_addr, mem_data_in}, {2'b11, 16'h0040, 16'h1234});
    tick(); d_mem_write = 0; #1;
    chk("wr_release", {mem_enable, mem_wr}, 2'b00);
    repeat (7) tick();
    chk("wr_no_data_valid", iq.size() + dq.size(), 0);

    // Protocol error: read and write together while D owns
    d_mem_read = 1; d_addr = 16'h0050;
    tick(); #1;
    chk("perr_before", {d_grant, mem_wr, protocol_err}, 3'b100);
    d_mem_write = 1; #1;
    chk("perr_write_wins", mem_wr, 1);
    chk("perr_not_yet", protocol_err, 0);
    tick(); #1;
    chk("perr_set", protocol_err, 1);
    d_mem_read = 0; d_mem_write = 0;
    repeat (3) tick(); #1;
    chk("perr_sticky", protocol_err, 1);

    // Reset with three reads in flight
    repeat (6) tick(); clr(); mv_cnt = 0;
    i_mem_read = 1; i_addr = 16'h0500;
    for (int k = 0; k < 3; k++) begin
      tick(); i_addr = 16'h0500 + 16'(2 * k);
    end
    #1;
    chk("rstmid_issuing", {i_grant, mem_enable}, 2'b11);
    tick(); rst = 1'b1; i_mem_read = 0; #1;
    chk("rstmid_grant", i_grant, 0);
    chk("rstmid_enable", mem_enable, 0);
    chk("rstmid_perr", protocol_err, 0);
    repeat (6) tick();
    chk("rstmid_mem_returns", mv_cnt, 3);
    chk("rstmid_dropped", iq.size() + dq.size(), 0);
    rst = 1'b0;
    tick(); #1;
    chk("rstmid_after", {i_grant, d_grant, mem_enable}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
